// File: rtl/bypass_skid_buffer.sv
// Registered valid/ready hop with a two-entry skid buffer: main register drives the output,
// skid register catches the one word that arrives while the consumer stalls.
//
// state | meaning
// EMPTY | no word held, Output_Valid=0, Input_Ready=1 (0 for the first cycle after reset)
// BUSY  | one word in main, Output_Valid=1, Input_Ready=1
// FULL  | main and skid both hold words, Output_Valid=1, Input_Ready=0
module bypass_skid_buffer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] Input_Data,
  input  logic                  Input_Valid,
  output logic                  Input_Ready,
  output logic [DATA_WIDTH-1:0] Output_Data,
  output logic                  Output_Valid,
  input  logic                  Output_Ready,
  output logic [1:0]            Occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, main_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  in_fire, out_fire;

  assign in_fire  = Input_Valid & in_ready_q;
  assign out_fire = out_valid_q & Output_Ready;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q     <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          main_d  = Input_Data;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (in_fire && out_fire) begin
          main_d = Input_Data;
        end else if (in_fire) begin
          skid_d  = Input_Data;
          state_d = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Input_Ready is low here, so only the drain of main can happen.
        if (out_fire) begin
          main_d  = skid_q;
          state_d = BUSY;
        end
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);
  end

  assign Input_Ready  = in_ready_q;
  assign Output_Valid = out_valid_q;
  assign Output_Data  = main_q;
  assign Occupancy    = state_q;

endmodule

// File: tb/tb_bypass_skid_buffer.sv
// Scoreboard bench for bypass_skid_buffer: stimulus pushes expected words, a negedge
// monitor pops and compares on every output handshake.
module tb_bypass_skid_buffer;

  logic       Clock;
  logic       Reset;
  logic [7:0] Input_Data;
  logic       Input_Valid;
  logic       Input_Ready;
  logic [7:0] Output_Data;
  logic       Output_Valid;
  logic       Output_Ready;
  logic [1:0] Occupancy;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  bypass_skid_buffer #(.DATA_WIDTH(8)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .Input_Data   (Input_Data),
    .Input_Valid  (Input_Valid),
    .Input_Ready  (Input_Ready),
    .Output_Data  (Output_Data),
    .Output_Valid (Output_Valid),
    .Output_Ready (Output_Ready),
    .Occupancy    (Occupancy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Monitor: every output handshake must match the head of the scoreboard.
  always @(negedge Clock) begin
    if (!Reset) begin
      chk("occ_range", {31'd0, Occupancy != 2'd3}, 32'd1);
      if (Output_Valid && Output_Ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out: got %0h expected none at %0t", Output_Data, $time);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          chk("out_data", Output_Data, e);
        end
      end
    end
  end

  initial begin
    int sent;
    int cyc;
    logic fire;
    Reset        = 1'b1;
    Input_Valid  = 1'b0;
    Input_Data   = 8'h00;
    Output_Ready = 1'b0;
    tick();
    tick();
    chk("rst_valid", Output_Valid, 0);
    chk("rst_data",  Output_Data, 0);
    chk("rst_occ",   Occupancy, 0);
    chk("rst_ready", Input_Ready, 0);
    Reset = 1'b0;
    tick();
    chk("ready_after_rst", Input_Ready, 1);

    // Output_Ready with nothing held does nothing
    Output_Ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_valid", Output_Valid, 0);
      chk("idle_occ",   Occupancy, 0);
    end

    // streaming 0x11,0x22,0x33 with 1-cycle latency
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    Input_Valid = 1'b1;
    Input_Data  = 8'h11;
    tick();
    chk("s1_valid", Output_Valid, 1);
    chk("s1_occ",   Occupancy, 1);
    Input_Data = 8'h22;
    tick();
    chk("s2_occ", Occupancy, 1);
    Input_Data = 8'h33;
    tick();
    chk("s3_occ", Occupancy, 1);
    Input_Valid = 1'b0;
    tick();
    chk("s_drain_occ", Occupancy, 0);
    chk("s_q_empty", exp_q.size(), 0);

    // backpressure: fill to FULL, third word held off
    Output_Ready = 1'b0;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hFF);
    Input_Valid = 1'b1;
    Input_Data  = 8'hA5;
    tick();
    chk("bp1_occ",   Occupancy, 1);
    chk("bp1_ready", Input_Ready, 1);
    chk("bp1_data",  Output_Data, 8'hA5);
    Input_Data = 8'h5A;
    tick();
    chk("bp2_occ",   Occupancy, 2);
    chk("bp2_ready", Input_Ready, 0);
    chk("bp2_data",  Output_Data, 8'hA5);
    Input_Data = 8'hFF;
    tick();
    chk("bp3_occ",   Occupancy, 2);
    chk("bp3_data",  Output_Data, 8'hA5);
    chk("bp3_valid", Output_Valid, 1);
    Output_Ready = 1'b1;
    tick();
    chk("bp4_data",  Output_Data, 8'h5A);
    chk("bp4_occ",   Occupancy, 1);
    chk("bp4_ready", Input_Ready, 1);
    tick();
    chk("bp5_data", Output_Data, 8'hFF);
    Input_Valid = 1'b0;
    tick();
    chk("bp_drain_occ", Occupancy, 0);
    chk("bp_q_empty", exp_q.size(), 0);

    // simultaneous in_fire and out_fire in BUSY
    Output_Ready = 1'b0;
    exp_q.push_back(8'h10);
    exp_q.push_back(8'h20);
    Input_Valid = 1'b1;
    Input_Data  = 8'h10;
    tick();
    chk("sim_pre_data", Output_Data, 8'h10);
    Output_Ready = 1'b1;
    Input_Data   = 8'h20;
    tick();
    chk("sim_data", Output_Data, 8'h20);
    chk("sim_occ",  Occupancy, 1);
    Input_Valid = 1'b0;
    tick();
    chk("sim_drain_occ", Occupancy, 0);

    // reset from FULL discards both words
    Output_Ready = 1'b0;
    Input_Valid  = 1'b1;
    Input_Data   = 8'h01;
    tick();
    Input_Data = 8'h02;
    tick();
    Input_Valid = 1'b0;
    chk("full_occ", Occupancy, 2);
    Reset = 1'b1;
    tick();
    exp_q.delete();
    chk("rf_valid", Output_Valid, 0);
    chk("rf_data",  Output_Data, 0);
    chk("rf_occ",   Occupancy, 0);
    chk("rf_ready", Input_Ready, 0);
    Reset = 1'b0;
    tick();
    chk("rf_ready_back", Input_Ready, 1);
    Output_Ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("rf_no_output", Output_Valid, 0);

    // random traffic, 1000 incrementing words
    sent        = 0;
    cyc         = 0;
    Input_Data  = 8'h00;
    Input_Valid = 1'($urandom_range(0, 1));
    while (sent < 1000 && cyc < 20000) begin
      Output_Ready = 1'($urandom_range(0, 1));
      @(negedge Clock);
      fire = Input_Valid && Input_Ready;
      if (fire) exp_q.push_back(Input_Data);
      tick();
      cyc++;
      if (fire) begin
        sent++;
        Input_Data = Input_Data + 8'd1;
      end
      if (sent >= 1000) Input_Valid = 1'b0;
      else if (fire || !Input_Valid) Input_Valid = 1'($urandom_range(0, 1));
    end
    chk("rand_sent", sent, 1000);
    Input_Valid  = 1'b0;
    Output_Ready = 1'b1;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      tick();
      cyc++;
    end
    tick();
    chk("rand_q_empty", exp_q.size(), 0);
    chk("rand_end_occ", Occupancy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
